rc4_stream_ctrl: RTL and testbench

Sequencing controller for the team's RC4 keystream core: accepts a key/message configuration, resets and starts the core, buffers the keystream bytes the core emits (the core cannot be stalled), and XORs them one-for-one onto a valid/ready byte stream to produce ciphertext or plaintext. Sits between the host-side config and data interfaces and a single RC4 core instance.

---
 rtl/rc4_stream_ctrl_if.sv | 45 ++++
 rtl/rc4_stream_ctrl.sv | 169 ++++++++++++++++
 tb/tb_rc4_stream_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_stream_ctrl_if.sv
// Host-side config, byte-stream and RC4 core signals for rc4_stream_ctrl.
// The slave modport is the controller's view; the master modport drives it.
interface rc4_stream_ctrl_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_key;
    logic [7:0]  cfg_key_len;
    logic [15:0] cfg_msg_len;

    logic        core_rst_n;
    logic        core_start;
    logic [31:0] core_key;
    logic [7:0]  core_key_len;
    logic        core_ks_valid;
    logic [7:0]  core_ks_byte;
    logic        core_done;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;

    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;

    logic        busy;
    logic [1:0]  err;

    modport slave (
        input  cfg_valid, cfg_key, cfg_key_len, cfg_msg_len,
        input  core_ks_valid, core_ks_byte, core_done,
        input  in_valid, in_data, out_ready,
        output cfg_ready, core_rst_n, core_start, core_key, core_key_len,
        output in_ready, out_valid, out_data, out_last, busy, err
    );

    modport master (
        output cfg_valid, cfg_key, cfg_key_len, cfg_msg_len,
        output core_ks_valid, core_ks_byte, core_done,
        output in_valid, in_data, out_ready,
        input  cfg_ready, core_rst_n, core_start, core_key, core_key_len,
        input  in_ready, out_valid, out_data, out_last, busy, err
    );
endinterface

// File: rtl/rc4_stream_ctrl.sv
// Sequences an RC4 keystream core, buffers its unstallable keystream in a small
// FIFO and XORs it one-for-one onto a valid/ready byte stream.
module rc4_stream_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    rc4_stream_ctrl_if.slave bus
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        CRST,
        START,
        STREAM,
        FLUSH
    } state_t;

    state_t state, next_state;

    logic [31:0]   key_q;
    logic [7:0]    key_len_q;
    logic [15:0]   remaining;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    out_data_q;
    logic          out_valid_q, out_last_q;
    logic [1:0]    err_q;

    logic cfg_accept, cfg_legal, out_free, in_ready_c, pop, room, push, drop, underrun;
    logic cfg_ready_c, core_rst_n_c, core_start_c, busy_c;

    always_comb begin
        cfg_accept = (state == IDLE) && bus.cfg_valid;
        cfg_legal  = (bus.cfg_key_len >= 8'd1) && (bus.cfg_key_len <= 8'd4) && (bus.cfg_msg_len != 16'd0);
        out_free   = !out_valid_q || bus.out_ready;
        in_ready_c = (state == STREAM) && (count != '0) && out_free;
        pop        = in_ready_c && bus.in_valid;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts
        room       = (count < DEPTH_C) || pop;
        push       = (state == STREAM) && bus.core_ks_valid && room;
        drop       = (state == STREAM) && bus.core_ks_valid && !room;
        underrun   = (state == STREAM) && bus.core_done && (count == '0) &&
                     (remaining != 16'd0) && !bus.core_ks_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        cfg_ready_c  = 1'b0;
        core_rst_n_c = rst_n;
        core_start_c = 1'b0;
        busy_c       = 1'b1;
        case (state)
            IDLE: begin
                busy_c      = 1'b0;
                cfg_ready_c = rst_n;
                if (bus.cfg_valid && cfg_legal) begin
                    next_state = CRST;
                end
            end
            CRST: begin
                core_rst_n_c = 1'b0;
                next_state   = START;
            end
            START: begin
                core_start_c = 1'b1;
                next_state   = STREAM;
            end
            STREAM: begin
                core_start_c = 1'b1;
                if ((pop && (remaining == 16'd1)) || underrun) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                core_start_c = 1'b1;
                if (out_free) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= bus.core_ks_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_q       <= '0;
            key_len_q   <= '0;
            remaining   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            err_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if (cfg_accept) begin
                key_q     <= bus.cfg_key;
                key_len_q <= bus.cfg_key_len;
                remaining <= bus.cfg_msg_len;
                err_q     <= '0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr    <= rd_ptr + AW'(1);
                    remaining <= remaining - 16'd1;
                end
                case ({push, pop})
                    2'b10:   count <= count + (AW + 1)'(1);
                    2'b01:   count <= count - (AW + 1)'(1);
                    default: count <= count;
                endcase
                if (drop) begin
                    err_q[0] <= 1'b1;
                end
                if (underrun) begin
                    err_q[1] <= 1'b1;
                end
            end

            // Output register only changes on a new transfer or a consumer handshake
            if (pop) begin
                out_data_q  <= bus.in_data ^ mem[rd_ptr];
                out_valid_q <= 1'b1;
                out_last_q  <= (remaining == 16'd1);
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign bus.cfg_ready    = cfg_ready_c;
    assign bus.core_rst_n   = core_rst_n_c;
    assign bus.core_start   = core_start_c;
    assign bus.core_key     = key_q;
    assign bus.core_key_len = key_len_q;
    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_last     = out_last_q;
    assign bus.busy         = busy_c;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_rc4_stream_ctrl.sv
// Self-checking bench for rc4_stream_ctrl: directed scenarios plus randomized
// messages scored against a queue-based reference model of the controller.
module tb_rc4_stream_ctrl;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rc4_stream_ctrl_if bus ();

    rc4_stream_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic driveIdle();
        bus.cfg_valid     = 1'b0;
        bus.cfg_key       = '0;
        bus.cfg_key_len   = '0;
        bus.cfg_msg_len   = '0;
        bus.core_ks_valid = 1'b0;
        bus.core_ks_byte  = '0;
        bus.core_done     = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.out_ready     = 1'b1;
    endtask

    // One message: the core emits a byte every 'gap' stream cycles until ks_total,
    // then holds core_done. Returns early at stream cycle abort_t (>=0).
    task automatic applyStimulus(input logic [31:0] key, input logic [7:0] klen, input logic [15:0] mlen,
                                 input int gap, input int ks_total, input int stall_start,
                                 input int stall_len, input int in_pct, input int rdy_pct,
                                 input bit seq_data, input int abort_t);
        logic [7:0] ksq[$];
        logic [7:0] ks, cur_in, m_od;
        logic [1:0] exp_err;
        bit legal, m_stream, m_flush, m_ov, m_ol, fin, ksv, cdone, ivalid, ordy, exp_ir, pop;
        int rem, emitted, n_in, sz0;

        exp_err  = 2'b00;
        legal    = (klen >= 8'd1) && (klen <= 8'd4) && (mlen != 16'd0);
        m_stream = 1'b1;
        m_flush  = 1'b0;
        m_ov     = 1'b0;
        m_ol     = 1'b0;
        m_od     = '0;
        fin      = 1'b0;
        rem      = int'(mlen);
        emitted  = 0;
        n_in     = 0;
        cur_in   = seq_data ? 8'd0 : 8'($urandom);

        @(negedge clk);
        driveIdle();
        bus.cfg_valid   = 1'b1;
        bus.cfg_key     = key;
        bus.cfg_key_len = klen;
        bus.cfg_msg_len = mlen;
        #1 checkOutput("cfg_ready_idle", 32'(bus.cfg_ready), 32'd1);

        @(negedge clk);
        bus.cfg_valid   = 1'b0;
        bus.cfg_key     = $urandom;
        bus.cfg_key_len = 8'($urandom);
        #1;
        if (!legal) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput("bad_cfg_busy", 32'(bus.busy), 32'd0);
                checkOutput("bad_cfg_core_rst_n", 32'(bus.core_rst_n), 32'd1);
                checkOutput("bad_cfg_core_start", 32'(bus.core_start), 32'd0);
                checkOutput("bad_cfg_cfg_ready", 32'(bus.cfg_ready), 32'd1);
                checkOutput("bad_cfg_err", 32'(bus.err), 32'd0);
                @(negedge clk);
                #1;
            end
            return;
        end

        checkOutput("crst_core_rst_n", 32'(bus.core_rst_n), 32'd0);
        checkOutput("crst_busy", 32'(bus.busy), 32'd1);
        checkOutput("crst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        checkOutput("core_key", bus.core_key, key);
        checkOutput("core_key_len", 32'(bus.core_key_len), 32'(klen));
        checkOutput("err_cleared", 32'(bus.err), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("start_core_start", 32'(bus.core_start), 32'd1);
        checkOutput("start_core_rst_n", 32'(bus.core_rst_n), 32'd1);

        for (int t = 0; t < 600 && !fin; t++) begin
            if (t == abort_t) return;
            @(negedge clk);
            ksv   = (emitted < ks_total) && ((t % gap) == 0);
            cdone = (emitted >= ks_total);
            bus.core_ks_valid = ksv;
            bus.core_ks_byte  = 8'($urandom);
            bus.core_done     = cdone;
            ivalid            = ($urandom_range(99) < in_pct);
            bus.in_valid      = ivalid;
            bus.in_data       = cur_in;
            ordy              = (t >= stall_start && t < stall_start + stall_len) ? 1'b0
                                                                                  : ($urandom_range(99) < rdy_pct);
            bus.out_ready     = ordy;
            if (ksv) emitted++;
            #1;

            checkOutput("out_valid", 32'(bus.out_valid), 32'(m_ov));
            if (m_ov) begin
                checkOutput("out_data", 32'(bus.out_data), 32'(m_od));
                checkOutput("out_last", 32'(bus.out_last), 32'(m_ol));
            end
            checkOutput("core_start_held", 32'(bus.core_start), 32'd1);
            sz0    = ksq.size();
            exp_ir = m_stream && (sz0 > 0) && (!m_ov || ordy);
            checkOutput("in_ready", 32'(bus.in_ready), 32'(exp_ir));
            pop = ivalid && exp_ir;

            if (m_flush && (!m_ov || ordy)) fin = 1'b1;

            if (pop) begin
                ks     = ksq.pop_front();
                m_od   = cur_in ^ ks;
                m_ol   = (rem == 1);
                m_ov   = 1'b1;
                rem--;
                n_in++;
                cur_in = seq_data ? 8'(n_in) : 8'($urandom);
            end else if (m_ov && ordy) begin
                m_ov = 1'b0;
            end

            if (m_stream) begin
                if (ksv) begin
                    if (ksq.size() < DEPTH) ksq.push_back(bus.core_ks_byte);
                    else exp_err[0] = 1'b1;
                end
                if (rem == 0) begin
                    m_stream = 1'b0;
                    m_flush  = 1'b1;
                end else if (cdone && sz0 == 0 && !ksv) begin
                    exp_err[1] = 1'b1;
                    m_stream   = 1'b0;
                    m_flush    = 1'b1;
                end
            end
        end
        if (!fin) checkOutput("msg_timeout", 32'd0, 32'd1);

        @(negedge clk);
        driveIdle();
        #1;
        checkOutput("end_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        checkOutput("end_busy", 32'(bus.busy), 32'd0);
        checkOutput("end_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("end_core_start", 32'(bus.core_start), 32'd0);
        checkOutput("end_err", 32'(bus.err), 32'(exp_err));
    endtask

    initial begin
        int mlen, total;
        driveIdle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        checkOutput("rst_core_rst_n", 32'(bus.core_rst_n), 32'd0);
        checkOutput("rst_core_start", 32'(bus.core_start), 32'd0);
        checkOutput("rst_core_key", bus.core_key, 32'd0);
        checkOutput("rst_core_key_len", 32'(bus.core_key_len), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
        checkOutput("rst_out_last", 32'(bus.out_last), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;

        // Basic message, sequential input data, core emitting every other cycle
        applyStimulus(32'h00030201, 8'd3, 16'd5, 2, 5, 1000, 0, 100, 100, 1'b1, -1);
        // Consumer stalled from the start: FIFO overfills and drops bytes
        applyStimulus(32'hA5A5_1234, 8'd4, 16'd4, 1, 6, 0, 10, 100, 100, 1'b0, -1);
        // Core finishes after 3 of 8 bytes: underrun
        applyStimulus(32'h0000_BEEF, 8'd2, 16'd8, 1, 3, 1000, 0, 100, 100, 1'b0, -1);
        // Illegal configurations are consumed without core activity and clear err
        applyStimulus(32'h1111_1111, 8'd0, 16'd4, 1, 4, 1000, 0, 100, 100, 1'b0, -1);
        applyStimulus(32'h2222_2222, 8'd5, 16'd4, 1, 4, 1000, 0, 100, 100, 1'b0, -1);
        applyStimulus(32'h3333_3333, 8'd1, 16'd0, 1, 4, 1000, 0, 100, 100, 1'b0, -1);
        // Fill the FIFO, then sustained push+pop while full
        applyStimulus(32'h0102_0304, 8'd4, 16'd16, 1, 20, 0, 5, 100, 100, 1'b0, -1);

        // Reset in the middle of a stalled stream
        applyStimulus(32'hCAFE_F00D, 8'd4, 16'd10, 1, 20, 0, 100, 100, 100, 1'b0, 8);
        @(negedge clk);
        driveIdle();
        rst_n = 1'b0;
        #1;
        checkOutput("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("pre_reset_err", 32'(bus.err), 32'd1);
        checkOutput("mid_rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        checkOutput("mid_rst_core_rst_n", 32'(bus.core_rst_n), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("post_rst_err", 32'(bus.err), 32'd0);
        checkOutput("post_rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("post_rst_core_start", 32'(bus.core_start), 32'd0);
        checkOutput("post_rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        applyStimulus(32'h0000_0042, 8'd1, 16'd6, 1, 6, 1000, 0, 100, 100, 1'b1, -1);

        // Randomized messages
        for (int i = 0; i < 10; i++) begin
            mlen  = int'($urandom_range(12, 1));
            total = int'($urandom_range(mlen + 3, (mlen > 2) ? mlen - 2 : 1));
            applyStimulus($urandom, 8'($urandom_range(4, 1)), 16'(mlen), int'($urandom_range(3, 1)), total,
                          int'($urandom_range(10, 0)), int'($urandom_range(6, 0)),
                          int'($urandom_range(100, 40)), int'($urandom_range(100, 40)), 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
